jk_counter_nbit: RTL

- Parametrised synchronous up/down counter; successor to the fixed 4-bit JK-style ripple-enable counter.
- Adds programmable width and modulus, direction control, parallel load, wrap or saturate mode, terminal-count and wrap-event outputs.
- Used as a generic sequencing/timebase counter in the lab datapath blocks.

---
 rtl/jk_counter_nbit.sv | 113 +++++++++++
 1 files changed

// File: rtl/jk_counter_nbit.sv
// rtl/jk_counter_nbit.sv - parametrised modulo-N up/down counter with load, wrap/saturate, tc, wrap pulse and sticky ovf
// Optional Gray-coded output enabled by defining JK_COUNTER_GRAY_OUT_EN.
module jk_counter_nbit #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
`ifdef JK_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] gray_q
`endif
);

  // Highest legal count; loads above it clamp here.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam bit               SAT_EN  = (SATURATE != 0);

  // Parameter legality, caught at elaboration.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("jk_counter_nbit: WIDTH must be 1..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("jk_counter_nbit: MODULUS must be 2..2**WIDTH");
  end
`ifdef JK_COUNTER_GRAY_OUT_EN
  if (MODULUS != (64'd1 << WIDTH)) begin : g_bad_gray
    $error("jk_counter_nbit: Gray output requires MODULUS == 2**WIDTH");
  end
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bot;

  assign at_top = (count_q == MAX_VAL);
  assign at_bot = (count_q == '0);

  // Next-state: load beats count; a boundary hit either wraps or holds and always flags wrap/ovf.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
          count_d = SAT_EN ? count_q : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_bot) begin
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
          count_d = SAT_EN ? count_q : MAX_VAL;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
  // Combinational carry-out for chaining into the next stage's en.
  assign tc   = en & ((up & at_top) | (~up & at_bot));

`ifdef JK_COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_reg_q, gray_d;

  assign gray_d = count_d ^ (count_d >> 1);

  // Gray register tracks the next count so it always equals gray(q).
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_reg_q <= '0;
    end else begin
      gray_reg_q <= gray_d;
    end
  end

  assign gray_q = gray_reg_q;
`endif

endmodule
